// File: rtl/div_hilo_ctrl.sv
// HI/LO owner and sequencer for an external iterative divider: accepts DIV/DIVU and
// MTHI/MTLO, pulses the divider start, writes remainder->HI / quotient->LO, stalls while busy.
module div_hilo_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned TIMEOUT     = 64,
  parameter bit          ZERO_BYPASS = 1'b1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             req_i,
  input  logic             op_signed_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             hilo_rd_i,
  output logic             stall_o,
  output logic             md_busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             timeout_err_o,
  output logic             div_signed_o,
  output logic [WIDTH-1:0] div_dividend_o,
  output logic [WIDTH-1:0] div_divisor_o,
  output logic             div_start_o,
  input  logic             div_busy_i,
  input  logic [WIDTH-1:0] div_q_i,
  input  logic [WIDTH-1:0] div_r_i
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, ARM, WAIT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             terr_q, terr_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      terr_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      terr_q  <= terr_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    terr_d  = terr_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        // req wins over a same-cycle MTHI/MTLO; the write is dropped
        if (req_i) begin
          if (ZERO_BYPASS && (opb_i == '0)) begin
            hi_d    = opa_i;
            lo_d    = '1;
            state_d = DONE;
          end else begin
            a_d     = opa_i;
            b_d     = opb_i;
            sgn_d   = op_signed_i;
            tcnt_d  = '0;
            state_d = LAUNCH;
          end
        end else begin
          if (mthi_i) hi_d = wdata_i;
          if (mtlo_i) lo_d = wdata_i;
        end
      end
      LAUNCH: state_d = ARM;
      ARM: begin
        tcnt_d = tcnt_q + 1'b1;
        if (div_busy_i) begin
          state_d = WAIT;
        end else if (tcnt_q == TLAST) begin
          terr_d  = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        if (!div_busy_i) begin
          hi_d    = div_r_i;
          lo_d    = div_q_i;
          state_d = DONE;
        end else if (tcnt_q == TLAST) begin
          terr_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign md_busy_o      = (state_q != IDLE);
  assign stall_o        = md_busy_o & (req_i | mthi_i | mtlo_i | hilo_rd_i);
  assign done_o         = (state_q == DONE);
  assign div_start_o    = (state_q == LAUNCH);
  assign hi_o           = hi_q;
  assign lo_o           = lo_q;
  assign timeout_err_o  = terr_q;
  assign div_signed_o   = sgn_q;
  assign div_dividend_o = a_q;
  assign div_divisor_o  = b_q;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl: behavioural divider model, expected HI/LO/err queued
// at issue, checked by a monitor on every done pulse.
module tb_div_hilo_ctrl;
  localparam int W   = 32;
  localparam int TO  = 16;
  localparam int LAT = 5;

  logic         clk = 0, rst = 1;
  logic         req = 0, sgn = 0, mthi = 0, mtlo = 0, hrd = 0;
  logic [W-1:0] opa = 0, opb = 0, wdata = 0;
  logic         stall, mdb, done, terr, dsgn, dstart;
  logic [W-1:0] hi, lo, dda, ddb;
  logic         dbusy;
  logic [W-1:0] dq, dr;

  div_hilo_ctrl #(.WIDTH(W), .TIMEOUT(TO), .ZERO_BYPASS(1'b1)) dut (
    .clock_i(clk), .reset_i(rst), .req_i(req), .op_signed_i(sgn),
    .opa_i(opa), .opb_i(opb), .mthi_i(mthi), .mtlo_i(mtlo), .wdata_i(wdata),
    .hilo_rd_i(hrd), .stall_o(stall), .md_busy_o(mdb), .done_o(done),
    .hi_o(hi), .lo_o(lo), .timeout_err_o(terr), .div_signed_o(dsgn),
    .div_dividend_o(dda), .div_divisor_o(ddb), .div_start_o(dstart),
    .div_busy_i(dbusy), .div_q_i(dq), .div_r_i(dr));

  always #5 clk = ~clk;

  // behavioural divider: busy for LAT cycles after start, or forever while hang=1
  logic hang = 0;
  int   dcnt = 0, starts = 0;
  always @(posedge clk) begin
    if (rst) begin
      dbusy <= 0; dq <= 0; dr <= 0; dcnt <= 0;
    end else if (dstart) begin
      starts <= starts + 1;
      dbusy  <= 1; dcnt <= LAT;
      if (dsgn) begin
        dq <= $signed(dda) / $signed(ddb);
        dr <= $signed(dda) % $signed(ddb);
      end else begin
        dq <= dda / ddb;
        dr <= dda % ddb;
      end
    end else if (dbusy && !hang) begin
      if (dcnt <= 1) dbusy <= 0;
      dcnt <= dcnt - 1;
    end
  end

  typedef struct { logic [W-1:0] hi; logic [W-1:0] lo; logic terr; } exp_t;
  exp_t exq[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exq.pop_front();
        chk("done_hi", hi, e.hi);
        chk("done_lo", lo, e.lo);
        chk("done_terr", {31'd0, terr}, {31'd0, e.terr});
      end
    end
  end

  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic mh, input logic [W-1:0] wd);
    @(negedge clk);
    req = 1; sgn = s; opa = a; opb = b; mthi = mh; wdata = wd;
    @(posedge clk); #1;
    req = 0; mthi = 0;
  endtask

  task automatic push(input logic [W-1:0] h, input logic [W-1:0] l, input logic t);
    exp_t e;
    e.hi = h; e.lo = l; e.terr = t;
    exq.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    if (k == 200) chk({name, "_done_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int s0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", {31'd0, mdb}, 0);
    chk("rst_terr", {31'd0, terr}, 0);
    chk("rst_start", {31'd0, dstart}, 0);

    // DIV -7 / 2
    s0 = starts;
    push(32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    issue(1, 32'hFFFFFFF9, 32'd2, 0, 0);
    wait_done("div_neg");
    chk("div_neg_starts", 32'(starts - s0), 1);

    // DIVU 100 / 7 with hilo_rd held through the whole operation
    push(32'd2, 32'd14, 0);
    issue(0, 32'd100, 32'd7, 0, 0);
    hrd = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      chk("stall_busy", {31'd0, stall}, 1);
      if (done === 1'b1) break;
    end
    @(negedge clk);
    chk("stall_idle", {31'd0, stall}, 0);
    hrd = 0;

    // zero-divisor bypass
    s0 = starts;
    push(32'h1234, 32'hFFFFFFFF, 0);
    issue(0, 32'h1234, 32'd0, 0, 0);
    @(negedge clk);
    chk("zb_done_next", {31'd0, done}, 1);
    @(posedge clk); #1;
    chk("zb_starts", 32'(starts - s0), 0);

    // req + mthi same cycle: write dropped
    push(32'd2, 32'd3, 0);
    issue(0, 32'd20, 32'd6, 1, 32'hAA);
    wait_done("req_mthi");
    // mthi + mtlo alone
    @(negedge clk); mthi = 1; mtlo = 1; wdata = 32'hAA;
    @(posedge clk); #1 mthi = 0; mtlo = 0;
    @(negedge clk);
    chk("mthi_hi", hi, 32'hAA);
    chk("mtlo_lo", lo, 32'hAA);
    @(negedge clk); mtlo = 1; wdata = 32'h55;
    @(posedge clk); #1 mtlo = 0;
    @(negedge clk);
    chk("mtlo_only_lo", lo, 32'h55);
    chk("mtlo_only_hi", hi, 32'hAA);

    // hung divider -> timeout, HI/LO unchanged
    hang = 1;
    push(32'hAA, 32'h55, 1);
    issue(0, 32'd10, 32'd3, 0, 0);
    wait_done("timeout");
    hang = 0;
    repeat (3) @(posedge clk);
    #1;
    // sticky error survives a good divide
    push(32'd1, 32'd7, 1);
    issue(0, 32'd50, 32'd7, 0, 0);
    wait_done("sticky");

    // reset in WAIT: no writeback, no done
    issue(0, 32'd50, 32'd5, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, mdb}, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_terr", {31'd0, terr}, 0);
    repeat (LAT + 4) @(posedge clk);
    #1;
    push(32'd0, 32'd3, 0);
    issue(0, 32'd9, 32'd3, 0, 0);
    wait_done("post_rst");

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(exq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
